// File: rtl/adc_rx_frontend.sv
// adc_rx_frontend
// Parallel-ADC receive front end: sequences the ADC output enable and settle
// period, double-registers the data/overflow pins, converts offset binary to
// two's complement, and keeps overflow statistics plus a windowed peak
// magnitude for gain monitoring.
module adc_rx_frontend #(
  parameter int DATA_W        = 16,
  parameter int OFFSET_BIN    = 1,
  parameter int SETTLE_CYCLES = 64,
  parameter int OVF_CNT_W     = 16,
  parameter int WIN_LOG2      = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DATA_W-1:0]    adc_d,
  input  logic                 adc_of,
  output logic                 adc_oe_n,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_of,
  output logic                 out_valid,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic                 ovf_sticky,
  output logic [DATA_W-1:0]    peak,
  output logic                 peak_valid,
  output logic                 running
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  // Offset binary differs from two's complement only in the MSB.
  localparam logic [DATA_W-1:0] FMT_MASK =
    (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                state_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  oe_n_q;
  logic                  running_q;

  logic [DATA_W-1:0]     s1_data_q;
  logic                  s1_of_q;
  logic                  s1_vld_q;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_of_q;
  logic                  out_vld_q;

  logic [OVF_CNT_W-1:0]  ovf_cnt_q,  ovf_cnt_d;
  logic                  sticky_q,   sticky_d;
  logic                  ovf_hit_s;

  logic [DATA_W-1:0]     mag_s;
  logic [DATA_W-1:0]     run_max_q,  run_max_d;
  logic [WIN_LOG2-1:0]   win_cnt_q,  win_cnt_d;
  logic [DATA_W-1:0]     peak_q,     peak_d;
  logic                  peak_vld_q, peak_vld_d;

  // Absolute value of a two's-complement sample; the most negative code maps
  // to 2^(DATA_W-1), which still fits the unsigned result.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    if (x[DATA_W-1]) begin
      return (~x) + DATA_W'(1);
    end else begin
      return x;
    end
  endfunction

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Control FSM: output-enable, settle countdown and the running flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= {SETTLE_W{1'b0}};
      oe_n_q    <= 1'b1;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q   <= ST_SETTLE;
            settle_q  <= SETTLE_LOAD;
            oe_n_q    <= 1'b0;
            running_q <= 1'b0;
          end else begin
            oe_n_q    <= 1'b1;
            running_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            oe_n_q    <= 1'b1;
            running_q <= 1'b0;
          end else if (settle_q == {SETTLE_W{1'b0}}) begin
            state_q   <= ST_RUN;
            oe_n_q    <= 1'b0;
            running_q <= 1'b1;
          end else begin
            settle_q  <= settle_q - SETTLE_W'(1);
            oe_n_q    <= 1'b0;
            running_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            oe_n_q    <= 1'b1;
            running_q <= 1'b0;
          end else begin
            oe_n_q    <= 1'b0;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          oe_n_q    <= 1'b1;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage input pipeline; the valid bit is tagged at stage 1 and rides
  // with the sample so in-flight samples still emerge after a disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q  <= {DATA_W{1'b0}};
      s1_of_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      out_data_q <= {DATA_W{1'b0}};
      out_of_q   <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      s1_data_q  <= adc_d;
      s1_of_q    <= adc_of;
      s1_vld_q   <= (state_q == ST_RUN);
      out_data_q <= s1_data_q ^ FMT_MASK;
      out_of_q   <= s1_of_q;
      out_vld_q  <= s1_vld_q;
    end
  end

  assign ovf_hit_s = out_vld_q & out_of_q;

  // Overflow statistics; a clear still counts a coincident overflowed sample.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    sticky_d  = sticky_q;
    if (ovf_clr) begin
      ovf_cnt_d = ovf_hit_s ? OVF_CNT_W'(1) : {OVF_CNT_W{1'b0}};
      sticky_d  = ovf_hit_s;
    end else if (ovf_hit_s) begin
      if (ovf_cnt_q != {OVF_CNT_W{1'b1}}) begin
        ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end else begin
        ovf_cnt_d = ovf_cnt_q;
      end
      sticky_d = 1'b1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
      sticky_d  = sticky_q;
    end
  end

  assign mag_s = abs_val(out_data_q);

  // Windowed peak: a partial window is dropped whenever the block is not running.
  always_comb begin
    run_max_d  = run_max_q;
    win_cnt_d  = win_cnt_q;
    peak_d     = peak_q;
    peak_vld_d = 1'b0;
    if (state_q != ST_RUN) begin
      run_max_d = {DATA_W{1'b0}};
      win_cnt_d = {WIN_LOG2{1'b0}};
    end else if (out_vld_q) begin
      if (win_cnt_q == {WIN_LOG2{1'b1}}) begin
        peak_d     = umax(run_max_q, mag_s);
        peak_vld_d = 1'b1;
        run_max_d  = {DATA_W{1'b0}};
        win_cnt_d  = {WIN_LOG2{1'b0}};
      end else begin
        run_max_d = umax(run_max_q, mag_s);
        win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      end
    end else begin
      run_max_d = run_max_q;
      win_cnt_d = win_cnt_q;
    end
  end

  // Statistics and peak state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_q  <= {OVF_CNT_W{1'b0}};
      sticky_q   <= 1'b0;
      run_max_q  <= {DATA_W{1'b0}};
      win_cnt_q  <= {WIN_LOG2{1'b0}};
      peak_q     <= {DATA_W{1'b0}};
      peak_vld_q <= 1'b0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      sticky_q   <= sticky_d;
      run_max_q  <= run_max_d;
      win_cnt_q  <= win_cnt_d;
      peak_q     <= peak_d;
      peak_vld_q <= peak_vld_d;
    end
  end

  assign adc_oe_n   = oe_n_q;
  assign running    = running_q;
  assign out_data   = out_data_q;
  assign out_of     = out_of_q;
  assign out_valid  = out_vld_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign ovf_sticky = sticky_q;
  assign peak       = peak_q;
  assign peak_valid = peak_vld_q;

endmodule

// File: tb/tb_adc_rx_frontend.sv
// tb_adc_rx_frontend
// Self-checking bench: a sample-level reference model derived from the block's
// documented behaviour predicts every output; each scenario task compares the
// DUT against the model and against the documented timing constants.
module tb_adc_rx_frontend;

  localparam int SETTLE  = 4;
  localparam int WINL    = 2;
  localparam int WIN_LEN = 1 << WINL;
  localparam int OVFW    = 3;
  localparam int OVF_MAX = (1 << OVFW) - 1;

  localparam logic [15:0] PK_VALS [8] = '{16'h0064, 16'hFED4, 16'h0032, 16'h8000,
                                          16'h0001, 16'h0002, 16'h0003, 16'h0004};
  localparam logic [15:0] RS_VALS [4] = '{16'h0007, 16'hFFF7, 16'h0003, 16'h0005};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] adc_d;
  logic        adc_of;
  logic        adc_oe_n;
  logic [15:0] out_data;
  logic        out_of;
  logic        out_valid;
  logic        ovf_clr;
  logic [2:0]  ovf_cnt;
  logic        ovf_sticky;
  logic [15:0] peak;
  logic        peak_valid;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  adc_rx_frontend #(
    .DATA_W(16), .OFFSET_BIN(1), .SETTLE_CYCLES(SETTLE),
    .OVF_CNT_W(OVFW), .WIN_LOG2(WINL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_d(adc_d), .adc_of(adc_of),
    .adc_oe_n(adc_oe_n), .out_data(out_data), .out_of(out_of), .out_valid(out_valid),
    .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky), .peak(peak),
    .peak_valid(peak_valid), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model state (sample level).
  int          en_cnt;
  bit          m_oe_n, m_run, m_v1, m_vld, m_of, m_s1_of, m_pv, m_sticky;
  logic [15:0] m_s1_d, m_data;
  int          m_ovf, m_peak;
  int          win_q[$];

  function automatic int mag(logic [15:0] x);
    if (x[15]) return 65536 - int'(x);
    else return int'(x);
  endfunction

  task automatic model_reset();
    en_cnt = 0; m_oe_n = 1'b1; m_run = 1'b0; m_v1 = 1'b0; m_vld = 1'b0;
    m_of = 1'b0; m_s1_of = 1'b0; m_pv = 1'b0; m_sticky = 1'b0;
    m_s1_d = 16'h0000; m_data = 16'h0000; m_ovf = 0; m_peak = 0;
    win_q.delete();
  endtask

  // One clock edge of the reference model, using pre-edge values.
  task automatic model_step();
    bit hit;
    int mx;
    hit = m_vld && m_of;
    if (ovf_clr) begin
      m_ovf = hit ? 1 : 0; m_sticky = hit;
    end else if (hit) begin
      if (m_ovf < OVF_MAX) m_ovf++;
      m_sticky = 1'b1;
    end
    m_pv = 1'b0;
    if (!m_run) win_q.delete();
    else if (m_vld) begin
      win_q.push_back(mag(m_data));
      if (win_q.size() == WIN_LEN) begin
        mx = 0;
        foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
        m_peak = mx; m_pv = 1'b1; win_q.delete();
      end
    end
    m_vld = m_v1; m_of = m_s1_of; m_data = m_s1_d ^ 16'h8000;
    m_v1 = m_run; m_s1_d = adc_d; m_s1_of = adc_of;
    en_cnt = enable ? ((en_cnt < 1000) ? en_cnt + 1 : en_cnt) : 0;
    m_oe_n = (en_cnt == 0);
    m_run  = (en_cnt > SETTLE);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; adc_d = 16'h0000; adc_of = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (adc_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b expected 1", adc_oe_n); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    if (ovf_cnt !== 3'd0 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0d/%b expected 0/0", ovf_cnt, ovf_sticky); end
    if (peak !== 16'h0000 || peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_peak: got %0h/%b expected 0/0", peak, peak_valid); end
    if (out_data !== 16'h0000 || out_of !== 1'b0) begin n_fail++; $display("FAIL reset_out_data: got %0h/%b expected 0/0", out_data, out_of); end
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      adc_d = 16'($urandom);
      tick();
      n_checks += 2;
      if (adc_oe_n !== 1'b1) begin n_fail++; $display("FAIL idle_oe_n: got %b expected 1", adc_oe_n); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_startup();
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adc_d = 16'($urandom);
      tick();
      n_checks += 3;
      if (adc_oe_n !== 1'b0) begin n_fail++; $display("FAIL start_oe_n edge %0d: got %b expected 0", k, adc_oe_n); end
      if (running !== (k >= SETTLE)) begin n_fail++; $display("FAIL start_running edge %0d: got %b expected %b", k, running, (k >= SETTLE)); end
      if (out_valid !== (k >= SETTLE + 2)) begin n_fail++; $display("FAIL start_out_valid edge %0d: got %b expected %b", k, out_valid, (k >= SETTLE + 2)); end
    end
  endtask

  task automatic test_format();
    logic [15:0] vals [12];
    vals[0] = 16'h0000; vals[1] = 16'h8000; vals[2] = 16'hFFFF;
    for (int i = 3; i < 12; i++) vals[i] = 16'($urandom);
    for (int i = 0; i < 13; i++) begin
      adc_d = (i < 12) ? vals[i] : 16'h1234;
      tick();
      if (i >= 1) begin
        n_checks += 2;
        if (out_data !== (vals[i-1] ^ 16'h8000)) begin n_fail++; $display("FAIL format_data %0d: got %0h expected %0h", i - 1, out_data, vals[i-1] ^ 16'h8000); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL format_valid %0d: got %b expected 1", i - 1, out_valid); end
      end
    end
  endtask

  task automatic test_overflow();
    adc_of = 1'b0; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    n_checks++;
    if (ovf_cnt !== 3'd0 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear0: got %0d/%b expected 0/0", ovf_cnt, ovf_sticky); end
    for (int i = 0; i < 5; i++) begin adc_of = 1'b1; adc_d = 16'($urandom); tick(); end
    adc_of = 1'b0; repeat (3) tick();
    n_checks += 2;
    if (ovf_cnt !== 3'd5) begin n_fail++; $display("FAIL ovf_cnt5: got %0d expected 5", ovf_cnt); end
    if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_sticky); end
    // Sixth overflow reaches out_valid exactly when the clear is applied.
    adc_of = 1'b1; tick(); adc_of = 1'b0; tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_checks++;
    if (ovf_cnt !== 3'd1 || ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_coincident: got %0d/%b expected 1/1", ovf_cnt, ovf_sticky); end
    for (int i = 0; i < 10; i++) begin adc_of = 1'b1; tick(); end
    adc_of = 1'b0; repeat (3) tick();
    n_checks += 2;
    if (ovf_cnt !== 3'd7) begin n_fail++; $display("FAIL ovf_saturate: got %0d expected 7", ovf_cnt); end
    if (ovf_cnt !== 3'(m_ovf)) begin n_fail++; $display("FAIL ovf_model: got %0d expected %0d", ovf_cnt, m_ovf); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_checks++;
    if (ovf_cnt !== 3'd0 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0d/%b expected 0/0", ovf_cnt, ovf_sticky); end
  endtask

  task automatic test_peak();
    int pulses;
    int seen [2];
    enable = 1'b0; repeat (3) tick();
    enable = 1'b1; tick();
    for (int k = 1; k <= SETTLE; k++) begin adc_d = 16'($urandom); tick(); end
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      adc_d = (i < 8) ? (PK_VALS[i] ^ 16'h8000) : 16'h8000;
      tick();
      n_checks += 2;
      if (peak_valid !== m_pv) begin n_fail++; $display("FAIL peak_valid %0d: got %b expected %b", i, peak_valid, m_pv); end
      if (peak !== 16'(m_peak)) begin n_fail++; $display("FAIL peak_model %0d: got %0d expected %0d", i, peak, m_peak); end
      if (peak_valid === 1'b1) begin
        if (pulses < 2) seen[pulses] = int'(peak);
        pulses++;
      end
    end
    n_checks += 3;
    if (pulses != 2) begin n_fail++; $display("FAIL peak_pulses: got %0d expected 2", pulses); end
    if (pulses >= 1 && seen[0] != 32768) begin n_fail++; $display("FAIL peak_win1: got %0d expected 32768", seen[0]); end
    if (pulses >= 2 && seen[1] != 4) begin n_fail++; $display("FAIL peak_win2: got %0d expected 4", seen[1]); end
  endtask

  task automatic test_disable_mid();
    enable = 1'b0; repeat (3) tick();
    enable = 1'b1; tick();
    for (int k = 1; k <= SETTLE + 1; k++) begin adc_d = 16'h0000; tick(); end
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      adc_d = 16'h0000;
      tick();
      n_checks += 3;
      if (adc_oe_n !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL dis_oe_run %0d: got %b/%b expected 1/0", k, adc_oe_n, running); end
      if (out_valid !== (k < 2)) begin n_fail++; $display("FAIL dis_out_valid %0d: got %b expected %b", k, out_valid, (k < 2)); end
      if (peak_valid !== 1'b0 || peak !== 16'd4) begin n_fail++; $display("FAIL dis_peak %0d: got %0d/%b expected 4/0", k, peak, peak_valid); end
    end
    // A fresh window after re-enable must not include the discarded samples.
    enable = 1'b1; tick();
    for (int k = 1; k <= SETTLE; k++) begin adc_d = 16'h0000; tick(); end
    for (int i = 0; i < 7; i++) begin
      adc_d = (i < 4) ? (RS_VALS[i] ^ 16'h8000) : 16'h8000;
      tick();
    end
    n_checks += 2;
    if (peak !== 16'd9) begin n_fail++; $display("FAIL restart_peak: got %0d expected 9", peak); end
    if (peak !== 16'(m_peak)) begin n_fail++; $display("FAIL restart_model: got %0d expected %0d", peak, m_peak); end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (out_valid !== 1'b1 || running !== 1'b1) begin n_fail++; $display("FAIL pre_reset_run: got %b/%b expected 1/1", out_valid, running); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks += 3;
    if (adc_oe_n !== 1'b1) begin n_fail++; $display("FAIL areset_oe_n: got %b expected 1", adc_oe_n); end
    if (out_valid !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b/%b expected 0/0", out_valid, running); end
    if (peak !== 16'h0000) begin n_fail++; $display("FAIL areset_peak: got %0d expected 0", peak); end
    #1 reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      adc_d = 16'($urandom);
      tick();
      n_checks += 3;
      if (adc_oe_n !== 1'b0) begin n_fail++; $display("FAIL rst_oe_n edge %0d: got %b expected 0", k, adc_oe_n); end
      if (running !== (k >= SETTLE)) begin n_fail++; $display("FAIL rst_running edge %0d: got %b expected %b", k, running, (k >= SETTLE)); end
      if (out_valid !== (k >= SETTLE + 2)) begin n_fail++; $display("FAIL rst_out_valid edge %0d: got %b expected %b", k, out_valid, (k >= SETTLE + 2)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 29) != 0);
      adc_d   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      adc_of  = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_checks += 5;
      if (adc_oe_n !== m_oe_n || running !== m_run) begin n_fail++; $display("FAIL rnd_ctrl %0d: got %b/%b expected %b/%b", i, adc_oe_n, running, m_oe_n, m_run); end
      if (out_valid !== m_vld || out_of !== m_of) begin n_fail++; $display("FAIL rnd_valid %0d: got %b/%b expected %b/%b", i, out_valid, out_of, m_vld, m_of); end
      if (out_data !== m_data) begin n_fail++; $display("FAIL rnd_data %0d: got %0h expected %0h", i, out_data, m_data); end
      if (ovf_cnt !== 3'(m_ovf) || ovf_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_ovf %0d: got %0d/%b expected %0d/%b", i, ovf_cnt, ovf_sticky, m_ovf, m_sticky); end
      if (peak !== 16'(m_peak) || peak_valid !== m_pv) begin n_fail++; $display("FAIL rnd_peak %0d: got %0d/%b expected %0d/%b", i, peak, peak_valid, m_peak, m_pv); end
    end
    ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_format();
    test_overflow();
    test_peak();
    test_disable_mid();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
